sisc_alu_ctrl: RTL and testbench
================================

SISC_ALU_CTRL -- requirements
Module: sisc_alu_ctrl

Interface
REQ-001 Parameter: DATA_W, default 32, datapath width of operands, result and write data.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_f  input  1  reset, asynchronous, active-high.
REQ-004 instruction  input  32  current instruction; opcode [31:28], mm/function [27:24], rd [23:20], rs [19:16], rt [15:12], imm [15:0]; held stable by environment from FETCH through WRITEBACK.
REQ-005 rsa  input  DATA_W  register-file read port A data (rs).
REQ-006 rsb  input  DATA_W  register-file read port B data.
REQ-007 alu_result  output  DATA_W  combinational ALU result.
REQ-008 write_data  output  DATA_W  writeback data (mux of alu_result and 0).
REQ-009 cc  output  4  combinational condition codes {C,V,N,Z} = cc[3:0].
REQ-010 stat_en  output  1  status-register load strobe.
REQ-011 rf_we  output  1  register-file write enable.
REQ-012 rb_sel  output  1  read-port-B address select (0 = rt, 1 = rd).

Function
REQ-013 FSM states: START0 -> START1 -> FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK -> FETCH; one state per cycle; HALT additional.
REQ-014 Opcodes: 4'h0 NOP; 4'h1 register ALU op (operand B = rsb); 4'h2 immediate ALU op (operand B = sign-extended imm[15:0]); 4'hF halt; all others treated as NOP.
REQ-015 In DECODE with opcode 4'hF, next state HALT; HALT is sticky until reset; all strobes 0 in HALT.
REQ-016 Function code mm: 0001 ADD, 0010 SUB (A-B), 0011 NOT A, 0100 OR, 0101 AND, 0110 XOR, 0111 SHL by B[4:0], 1000 logical SHR by B[4:0], 1001 ROL by B[4:0], 1010 ROR by B[4:0]; other codes unsupported.
REQ-017 Unsupported function or NOP: alu_result = 0, rf_we and stat_en never asserted.
REQ-018 ADD: C = carry-out, V = signed overflow; SUB computed as A + ~B + 1, C = carry-out (1 = no borrow), V = signed overflow; logic/shift ops: C = 0, V = 0.
REQ-019 N = alu_result[DATA_W-1]; Z = (alu_result == 0); results truncated to DATA_W (wrap-around).
REQ-020 rf_we = 1 and stat_en = 1 for exactly the WRITEBACK cycle of a supported opcode 4'h1/4'h2; 0 in all other cycles.
REQ-021 wb_sel (internal) = 0 for all implemented instructions; write_data = wb_sel ? 0 : alu_result.
REQ-022 rb_sel = 0 in every state for all implemented opcodes.
REQ-023 Strobes are registered from FSM state (Moore); no combinational path from instruction to rf_we/stat_en.
REQ-024 Instruction cycle = 5 clocks (FETCH..WRITEBACK); first FETCH is the 3rd rising edge after reset release.

Reset
REQ-025 rst_f high: state -> START0 immediately; rf_we, stat_en, rb_sel, wb_sel = 0 without waiting for clk.
REQ-026 Reset mid-instruction aborts it; no register or status write occurs for that instruction.
REQ-027 Reset exits HALT.

Configuration
REQ-028 Macro SISC_SHIFT_EN defined: functions 0111-1010 supported per REQ-016.
REQ-029 SISC_SHIFT_EN undefined: functions 0111-1010 are unsupported per REQ-017; all other functions unchanged.

Verification
REQ-030 instruction 0x11312000, rsa=5, rsb=3 -> in WRITEBACK rf_we=1, stat_en=1, write_data=0x00000008, cc=4'b0000.
REQ-031 instruction 0x12312000, rsa=3, rsb=5 -> write_data=0xFFFFFFFE, cc=4'b0010 (C=0, N=1).
REQ-032 ADD rsa=0x7FFFFFFF, rsb=1 -> write_data=0x80000000, cc=4'b0110; ADD 0xFFFFFFFF+1 -> 0, cc=4'b1001.
REQ-033 instruction 0x2131FFFF, rsa=10 -> write_data=9 (imm sign-extended to -1), rf_we one cycle.
REQ-034 instruction 0xF0000000 -> FSM enters HALT after DECODE, rf_we/stat_en stay 0 for 20 cycles; rst_f pulse -> START0.
REQ-035 rst_f asserted during EXECUTE of an ADD -> rf_we never pulses; with SISC_SHIFT_EN undefined, mm=0111 -> rf_we stays 0.

Source files
------------

// File: rtl/sisc_alu_ctrl.sv
// SISC ALU datapath plus the fetch/decode/execute/mem/writeback control FSM.
// Optional shift/rotate functions (0111-1010) are built when SISC_SHIFT_EN is defined.
module sisc_alu_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] rsa,
  input  logic [DATA_W-1:0] rsb,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] write_data,
  output logic [3:0]        cc,
  output logic              stat_en,
  output logic              rf_we,
  output logic              rb_sel
);

  localparam int MSB = DATA_W - 1;

  typedef enum logic [2:0] {
    S_START0, S_START1, S_FETCH, S_DECODE,
    S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_e;

  state_e state_q;
  logic   rf_we_q, stat_en_q, rb_sel_q, wb_sel_q;

  logic [3:0]        opcode, mm;
  logic [DATA_W-1:0] op_a, op_b, res;
  logic [DATA_W:0]   sum_ext;
  logic              func_ok, supported, c_flag, v_flag;
  logic              unused_fields;

  assign opcode        = instruction[31:28];
  assign mm            = instruction[27:24];
  assign unused_fields = ^instruction[23:16];

  assign op_a = rsa;
  assign op_b = (opcode == 4'h2) ? {{(DATA_W-16){instruction[15]}}, instruction[15:0]} : rsb;

`ifdef SISC_SHIFT_EN
  logic [4:0]          amt;
  logic [2*DATA_W-1:0] rot_l, rot_r;
  assign amt     = op_b[4:0];
  assign rot_l   = {op_a, op_a} << amt;
  assign rot_r   = {op_a, op_a} >> amt;
  assign func_ok = (mm >= 4'h1) && (mm <= 4'hA);
`else
  assign func_ok = (mm >= 4'h1) && (mm <= 4'h6);
`endif

  assign supported = ((opcode == 4'h1) || (opcode == 4'h2)) && func_ok;

  always_comb begin
    res     = '0;
    c_flag  = 1'b0;
    v_flag  = 1'b0;
    sum_ext = '0;
    case (mm)
      4'h1: begin
        sum_ext = {1'b0, op_a} + {1'b0, op_b};
        res     = sum_ext[MSB:0];
        c_flag  = sum_ext[DATA_W];
        v_flag  = (op_a[MSB] == op_b[MSB]) && (res[MSB] != op_a[MSB]);
      end
      4'h2: begin
        // carry-out of A + ~B + 1 is the inverted borrow
        sum_ext = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};
        res     = sum_ext[MSB:0];
        c_flag  = sum_ext[DATA_W];
        v_flag  = (op_a[MSB] != op_b[MSB]) && (res[MSB] != op_a[MSB]);
      end
      4'h3: res = ~op_a;
      4'h4: res = op_a | op_b;
      4'h5: res = op_a & op_b;
      4'h6: res = op_a ^ op_b;
`ifdef SISC_SHIFT_EN
      4'h7: res = op_a << amt;
      4'h8: res = op_a >> amt;
      4'h9: res = rot_l[2*DATA_W-1:DATA_W];
      4'hA: res = rot_r[MSB:0];
`endif
      default: ;
    endcase
    if (!supported) begin
      res    = '0;
      c_flag = 1'b0;
      v_flag = 1'b0;
    end
  end

  assign alu_result = res;
  assign cc         = {c_flag, v_flag, res[MSB], (res == '0)};
  assign write_data = wb_sel_q ? '0 : res;

  // Strobes are loaded on the MEM->WRITEBACK edge so they are high for exactly that state.
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state_q   <= S_START0;
      rf_we_q   <= 1'b0;
      stat_en_q <= 1'b0;
      rb_sel_q  <= 1'b0;
      wb_sel_q  <= 1'b0;
    end else begin
      rf_we_q   <= 1'b0;
      stat_en_q <= 1'b0;
      rb_sel_q  <= 1'b0;
      wb_sel_q  <= 1'b0;
      case (state_q)
        S_START0:    state_q <= S_START1;
        S_START1:    state_q <= S_FETCH;
        S_FETCH:     state_q <= S_DECODE;
        S_DECODE:    state_q <= (opcode == 4'hF) ? S_HALT : S_EXECUTE;
        S_EXECUTE:   state_q <= S_MEM;
        S_MEM: begin
          state_q   <= S_WRITEBACK;
          rf_we_q   <= supported;
          stat_en_q <= supported;
        end
        S_WRITEBACK: state_q <= S_FETCH;
        S_HALT:      state_q <= S_HALT;
        default:     state_q <= S_START0;
      endcase
    end
  end

  assign rf_we   = rf_we_q;
  assign stat_en = stat_en_q;
  assign rb_sel  = rb_sel_q;

endmodule

// File: tb/tb_sisc_alu_ctrl.sv
// Directed bench for sisc_alu_ctrl: timing of the writeback strobe, ALU results/flags,
// halt, reset behaviour and (when SISC_SHIFT_EN is set) shift/rotate functions.
module tb_sisc_alu_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_f = 1'b1;
  logic [31:0]   instruction = '0;
  logic [W-1:0]  rsa = '0, rsb = '0;
  logic [W-1:0]  alu_result, write_data;
  logic [3:0]    cc;
  logic          stat_en, rf_we, rb_sel;

  int n_checks = 0;
  int n_fail   = 0;

  sisc_alu_ctrl #(.DATA_W(W)) dut (
    .clk(clk), .rst_f(rst_f), .instruction(instruction), .rsa(rsa), .rsb(rsb),
    .alu_result(alu_result), .write_data(write_data), .cc(cc),
    .stat_en(stat_en), .rf_we(rf_we), .rb_sel(rb_sel)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_f = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_f = 1'b0;
  endtask

  // Counts rising edges until rf_we is seen high (sampled 1 time unit after the edge).
  task automatic wait_wb(input int limit, output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < limit) begin
      @(posedge clk);
      cyc++;
      #1;
      if (rf_we === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    instruction = 32'h11312000; rsa = 5; rsb = 3;
    rst_f = 1'b0;
    @(posedge clk); #2;
    rst_f = 1'b1;
    #1;
    n_checks++;
    if ({rf_we, stat_en, rb_sel} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes got=%b expected=000", {rf_we, stat_en, rb_sel});
    end
    @(negedge clk);
    rst_f = 1'b0;
  endtask

  task automatic test_add();
    bit seen; int cyc;
    instruction = 32'h11312000; rsa = 5; rsb = 3;
    do_reset();
    wait_wb(12, seen, cyc);
    n_checks++;
    if (!seen || cyc != 6) begin
      n_fail++; $display("FAIL add_latency seen=%0d cyc=%0d expected seen=1 cyc=6", seen, cyc);
    end
    n_checks++;
    if (write_data !== 32'h8 || cc !== 4'b0000 || stat_en !== 1'b1) begin
      n_fail++; $display("FAIL add_result wd=%h cc=%b st=%b expected wd=8 cc=0000 st=1", write_data, cc, stat_en);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b0 || stat_en !== 1'b0) begin
      n_fail++; $display("FAIL add_pulse_width we=%b st=%b expected 0 0", rf_we, stat_en);
    end
    // one edge of the next instruction already consumed: four more to its WRITEBACK
    wait_wb(12, seen, cyc);
    n_checks++;
    if (!seen || cyc != 4) begin
      n_fail++; $display("FAIL add_period seen=%0d cyc=%0d expected seen=1 cyc=4", seen, cyc);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] t_ins [8];
    logic [31:0] t_a [8], t_b [8], t_res [8];
    logic [3:0]  t_cc [8];
    bit seen; int cyc;
    t_ins[0] = 32'h12312000; t_a[0] = 3;            t_b[0] = 5; t_res[0] = 32'hFFFFFFFE; t_cc[0] = 4'b0010;
    t_ins[1] = 32'h11312000; t_a[1] = 32'h7FFFFFFF; t_b[1] = 1; t_res[1] = 32'h80000000; t_cc[1] = 4'b0110;
    t_ins[2] = 32'h11312000; t_a[2] = 32'hFFFFFFFF; t_b[2] = 1; t_res[2] = 32'h0;        t_cc[2] = 4'b1001;
    t_ins[3] = 32'h2131FFFF; t_a[3] = 10;           t_b[3] = 0; t_res[3] = 32'h9;        t_cc[3] = 4'b1000;
    t_ins[4] = 32'h14312000; t_a[4] = 32'hF0;       t_b[4] = 32'h0F; t_res[4] = 32'hFF;  t_cc[4] = 4'b0000;
    t_ins[5] = 32'h15312000; t_a[5] = 32'hF0;       t_b[5] = 32'h3C; t_res[5] = 32'h30;  t_cc[5] = 4'b0000;
    t_ins[6] = 32'h16312000; t_a[6] = 32'h1234;     t_b[6] = 32'h1234; t_res[6] = 32'h0; t_cc[6] = 4'b0001;
    t_ins[7] = 32'h13312000; t_a[7] = 0;            t_b[7] = 7; t_res[7] = 32'hFFFFFFFF; t_cc[7] = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      instruction = t_ins[i]; rsa = t_a[i]; rsb = t_b[i];
      do_reset();
      wait_wb(12, seen, cyc);
      n_checks++;
      if (!seen || write_data !== t_res[i] || cc !== t_cc[i] || stat_en !== 1'b1) begin
        n_fail++;
        $display("FAIL alu_op[%0d] seen=%0d wd=%h cc=%b st=%b expected wd=%h cc=%b st=1",
                 i, seen, write_data, cc, stat_en, t_res[i], t_cc[i]);
      end
      if (i == 3) begin
        @(posedge clk); #1;
        n_checks++;
        if (rf_we !== 1'b0) begin
          n_fail++; $display("FAIL imm_one_cycle we=%b expected 0", rf_we);
        end
      end
    end
  endtask

`ifdef SISC_SHIFT_EN
  task automatic test_shift();
    logic [31:0] t_ins [4], t_a [4], t_b [4], t_res [4];
    bit seen; int cyc;
    t_ins[0] = 32'h17312000; t_a[0] = 1;            t_b[0] = 4;  t_res[0] = 32'h10;
    t_ins[1] = 32'h18312000; t_a[1] = 32'h80000000; t_b[1] = 31; t_res[1] = 32'h1;
    t_ins[2] = 32'h19312000; t_a[2] = 32'h80000001; t_b[2] = 1;  t_res[2] = 32'h3;
    t_ins[3] = 32'h1A312000; t_a[3] = 32'h3;        t_b[3] = 33; t_res[3] = 32'h80000001;
    for (int i = 0; i < 4; i++) begin
      instruction = t_ins[i]; rsa = t_a[i]; rsb = t_b[i];
      do_reset();
      wait_wb(12, seen, cyc);
      n_checks++;
      if (!seen || write_data !== t_res[i] || cc[3:2] !== 2'b00) begin
        n_fail++;
        $display("FAIL shift[%0d] seen=%0d wd=%h cc=%b expected wd=%h cv=00", i, seen, write_data, cc, t_res[i]);
      end
    end
  endtask
`endif

  task automatic test_unsupported();
    logic [31:0] t_ins [5];
    bit seen; int cyc;
    t_ins[0] = 32'h10312000;
    t_ins[1] = 32'h00000000;
    t_ins[2] = 32'h31312000;
    t_ins[3] = 32'h1B312000;
`ifdef SISC_SHIFT_EN
    t_ins[4] = 32'h1F312000;
`else
    t_ins[4] = 32'h17312000;
`endif
    rsa = 5; rsb = 3;
    for (int i = 0; i < 5; i++) begin
      instruction = t_ins[i];
      do_reset();
      n_checks++;
      if (alu_result !== '0) begin
        n_fail++; $display("FAIL unsup_result[%0d] got=%h expected=0", i, alu_result);
      end
      wait_wb(14, seen, cyc);
      n_checks++;
      if (seen || stat_en !== 1'b0) begin
        n_fail++; $display("FAIL unsup_strobe[%0d] seen=%0d st=%b expected 0 0", i, seen, stat_en);
      end
    end
  endtask

  task automatic test_halt();
    bit seen; int cyc; int bad;
    instruction = 32'hF0000000; rsa = 5; rsb = 3;
    do_reset();
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({rf_we, stat_en, rb_sel} !== 3'b000) begin
        n_fail++; bad++;
        if (bad < 3) $display("FAIL halt_strobes cyc=%0d got=%b expected=000", i, {rf_we, stat_en, rb_sel});
      end
    end
    instruction = 32'h11312000;
    wait_wb(14, seen, cyc);
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL halt_sticky seen=%0d expected 0", seen);
    end
    do_reset();
    wait_wb(12, seen, cyc);
    n_checks++;
    if (!seen || cyc != 6 || write_data !== 32'h8) begin
      n_fail++; $display("FAIL halt_exit seen=%0d cyc=%0d wd=%h expected 1 6 8", seen, cyc, write_data);
    end
  endtask

  task automatic test_reset_mid();
    bit seen; int cyc; int bad;
    instruction = 32'h11312000; rsa = 5; rsb = 3;
    do_reset();
    repeat (4) @(posedge clk);
    #2 rst_f = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rf_we !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL reset_abort pulses=%0d expected 0", bad);
    end
    @(negedge clk);
    rst_f = 1'b0;
    wait_wb(12, seen, cyc);
    n_checks++;
    if (!seen || cyc != 6) begin
      n_fail++; $display("FAIL reset_restart seen=%0d cyc=%0d expected 1 6", seen, cyc);
    end
  endtask

  task automatic test_async_reset();
    bit seen; int cyc;
    instruction = 32'h11312000; rsa = 5; rsb = 3;
    do_reset();
    wait_wb(12, seen, cyc);
    #1 rst_f = 1'b1;
    #1;
    n_checks++;
    if (!seen || rf_we !== 1'b0 || stat_en !== 1'b0) begin
      n_fail++; $display("FAIL async_reset seen=%0d we=%b st=%b expected 1 0 0", seen, rf_we, stat_en);
    end
    @(negedge clk);
    rst_f = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit seen; int cyc;
    instruction = 32'h11312000; rsa = 5; rsb = 3;
    do_reset();
    wait_wb(12, seen, cyc);
    @(posedge clk); #1;
    instruction = 32'h12312000; rsa = 10; rsb = 4;
    wait_wb(12, seen, cyc);
    n_checks++;
    if (!seen || cyc != 4 || write_data !== 32'h6 || cc !== 4'b1000) begin
      n_fail++; $display("FAIL back_to_back seen=%0d cyc=%0d wd=%h cc=%b expected 1 4 6 1000", seen, cyc, write_data, cc);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
`ifdef SISC_SHIFT_EN
    test_shift();
`endif
    test_unsupported();
    test_halt();
    test_reset_mid();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
